b_to_ex: RTL and testbench

- Registered binary-to-excess-3 code converter for the Exp-6 code-converter group.
- Encode: out = in + 3. Decode (excess-3 back to binary): out = in − 3.
- Flags BCD-range violations and modular wrap so the downstream display/compare logic can reject bad digits.
- Sits between the operand register and the 7-seg/compare stage. One conversion per clock, no backpressure.

---
 rtl/b_to_ex_pkg.sv | 30 +++
 rtl/b_to_ex_core.sv | 54 +++++
 rtl/b_to_ex.sv | 67 ++++++
 tb/tb_b_to_ex.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/b_to_ex_pkg.sv
// Shared constants and a scoreboard reference for the binary/excess-3 converter.
// Default width, bias and BCD limit live here so the core, top and bench agree.
package b_to_ex_pkg;

    localparam int unsigned W_DEF       = 4;
    localparam int unsigned OFFSET_DEF  = 3;
    localparam int unsigned BCD_MAX_DEF = 9;

    localparam logic MODE_ENC = 1'b0;
    localparam logic MODE_DEC = 1'b1;

    // Returns {wrap, op} for the default width.
    // Encode: the carry bit of the widened sum is the wrap flag.
    // Decode: wrap is the borrow, i.e. value < OFFSET.
    function automatic logic [W_DEF:0] excess3_ref(input logic [W_DEF-1:0] value,
                                                   input logic             mode);
        logic [W_DEF:0]   sum_v;
        logic [W_DEF-1:0] diff_v;
        logic [W_DEF:0]   res_v;
        sum_v  = {1'b0, value} + (W_DEF+1)'(OFFSET_DEF);
        diff_v = value - W_DEF'(OFFSET_DEF);
        if (mode == MODE_ENC) begin
            res_v = sum_v;
        end else begin
            res_v = {(value < W_DEF'(OFFSET_DEF)), diff_v};
        end
        return res_v;
    endfunction

endpackage

// File: rtl/b_to_ex_core.sv
// Combinational excess-3 add/subtract with carry/borrow and BCD-range flags.
// Out-of-range operands still yield the modular result; flags are advisory.
module b_to_ex_core
    import b_to_ex_pkg::*;
#(
    parameter int unsigned W       = W_DEF,
    parameter int unsigned OFFSET  = OFFSET_DEF,
    parameter int unsigned BCD_MAX = BCD_MAX_DEF
) (
    input  logic [W-1:0] inp,
    input  logic         mode,
    output logic [W-1:0] op,
    output logic         wrap,
    output logic         range_err
);

    // Two spare bits keep BCD_MAX + OFFSET from truncating in the comparisons.
    localparam logic [W+1:0] OFF_X     = (W+2)'(OFFSET);
    localparam logic [W+1:0] BCD_X     = (W+2)'(BCD_MAX);
    localparam logic [W+1:0] DEC_MAX_X = (W+2)'(BCD_MAX + OFFSET);

    logic [W+1:0] inp_x_s;
    logic [W:0]   sum_s;
    logic [W-1:0] diff_s;

    assign inp_x_s = {2'b00, inp};
    assign sum_s   = {1'b0, inp} + (W+1)'(OFFSET);
    assign diff_s  = inp - W'(OFFSET);

    // Select encode or decode result and flags by mode.
    always_comb begin
        op        = sum_s[W-1:0];
        wrap      = 1'b0;
        range_err = 1'b0;
        case (mode)
            MODE_ENC: begin
                op        = sum_s[W-1:0];
                wrap      = sum_s[W];
                range_err = (inp_x_s > BCD_X);
            end
            MODE_DEC: begin
                op        = diff_s;
                wrap      = (inp_x_s < OFF_X);
                range_err = (inp_x_s < OFF_X) || (inp_x_s > DEC_MAX_X);
            end
            default: begin
                op        = sum_s[W-1:0];
                wrap      = sum_s[W];
                range_err = (inp_x_s > BCD_X);
            end
        endcase
    end

endmodule

// File: rtl/b_to_ex.sv
// Registered binary <-> excess-3 converter: one conversion per clock, 1-cycle latency.
// Result and flags hold across idle cycles so the display stage sees no toggling.
module b_to_ex
    import b_to_ex_pkg::*;
#(
    parameter int unsigned W       = W_DEF,
    parameter int unsigned OFFSET  = OFFSET_DEF,
    parameter int unsigned BCD_MAX = BCD_MAX_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] inp,
    input  logic         in_valid,
    input  logic         mode,
    output logic [W-1:0] op,
    output logic         out_valid,
    output logic         wrap,
    output logic         range_err
);

    logic [W-1:0] core_op_s;
    logic         core_wrap_s;
    logic         core_range_err_s;

    logic [W-1:0] op_r;
    logic         out_valid_r;
    logic         wrap_r;
    logic         range_err_r;

    b_to_ex_core #(
        .W       (W),
        .OFFSET  (OFFSET),
        .BCD_MAX (BCD_MAX)
    ) u_core (
        .inp       (inp),
        .mode      (mode),
        .op        (core_op_s),
        .wrap      (core_wrap_s),
        .range_err (core_range_err_s)
    );

    // Output register stage: reset clears, valid loads, idle holds data.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_r        <= '0;
            out_valid_r <= 1'b0;
            wrap_r      <= 1'b0;
            range_err_r <= 1'b0;
        end else if (in_valid) begin
            op_r        <= core_op_s;
            out_valid_r <= 1'b1;
            wrap_r      <= core_wrap_s;
            range_err_r <= core_range_err_s;
        end else begin
            op_r        <= op_r;
            out_valid_r <= 1'b0;
            wrap_r      <= wrap_r;
            range_err_r <= range_err_r;
        end
    end

    assign op        = op_r;
    assign out_valid = out_valid_r;
    assign wrap      = wrap_r;
    assign range_err = range_err_r;

endmodule

// File: tb/tb_b_to_ex.sv
// Self-checking bench for b_to_ex: directed plan plus random traffic against an
// integer-arithmetic model of the conversion rules.
module tb_b_to_ex;
    import b_to_ex_pkg::*;

    logic       clk;
    logic       rst;
    logic [3:0] inp;
    logic       in_valid;
    logic       mode;
    logic [3:0] op;
    logic       out_valid;
    logic       wrap;
    logic       range_err;

    int tests;
    int fails;

    // Model of the registered outputs.
    int m_op;
    int m_ov;
    int m_wrap;
    int m_rerr;

    b_to_ex dut (
        .clk       (clk),
        .rst       (rst),
        .inp       (inp),
        .in_valid  (in_valid),
        .mode      (mode),
        .op        (op),
        .out_valid (out_valid),
        .wrap      (wrap),
        .range_err (range_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Apply one cycle of stimulus, advance the model, and compare all outputs.
    task automatic step(input logic r, input logic iv, input logic md, input int v);
        int s;
        @(negedge clk);
        rst      = r;
        in_valid = iv;
        mode     = md;
        inp      = 4'(v);
        @(posedge clk);
        #1;
        if (r) begin
            m_op = 0; m_ov = 0; m_wrap = 0; m_rerr = 0;
        end else if (iv) begin
            m_ov = 1;
            if (md == 1'b0) begin
                s      = v + 3;
                m_op   = s % 16;
                m_wrap = (s >= 16) ? 1 : 0;
                m_rerr = (v > 9) ? 1 : 0;
            end else begin
                m_op   = (v - 3 + 16) % 16;
                m_wrap = (v < 3) ? 1 : 0;
                m_rerr = (v < 3 || v > 12) ? 1 : 0;
            end
        end else begin
            m_ov = 0;
        end
        chk("op",        int'(op),        m_op);
        chk("out_valid", int'(out_valid), m_ov);
        chk("wrap",      int'(wrap),      m_wrap);
        chk("range_err", int'(range_err), m_rerr);
    endtask

    initial begin
        logic [4:0] ref_v;
        logic       rr;
        logic       riv;
        logic       rmd;
        int         rv;
        tests = 0; fails = 0;
        m_op = 0; m_ov = 0; m_wrap = 0; m_rerr = 0;
        rst = 1'b1; in_valid = 1'b0; mode = 1'b0; inp = 4'd0;

        // Reset held two cycles with a valid operand present.
        step(1'b1, 1'b1, 1'b0, 5);
        step(1'b1, 1'b1, 1'b0, 5);
        step(1'b0, 1'b1, 1'b0, 5);
        chk("first_after_rst", int'(op), 8);

        // Encode sweep, including wrap points 13->0 and 15->2.
        for (int i = 0; i < 16; i++) step(1'b0, 1'b1, MODE_ENC, i);
        chk("enc15_op", int'(op), 2);
        chk("enc15_wrap", int'(wrap), 1);

        // Decode sweep.
        for (int i = 0; i < 16; i++) step(1'b0, 1'b1, MODE_DEC, i);
        chk("dec15_op", int'(op), 12);
        chk("dec15_rerr", int'(range_err), 1);

        // Round trip 7 -> 10 -> 7.
        step(1'b0, 1'b1, MODE_ENC, 7);
        chk("rt_enc", int'(op), 10);
        step(1'b0, 1'b1, MODE_DEC, int'(op));
        chk("rt_dec", int'(op), 7);
        chk("rt_flags", int'({wrap, range_err}), 0);

        // Gaps with mode flips: op must hold during idle cycles.
        step(1'b0, 1'b1, MODE_ENC, 4);
        step(1'b0, 1'b0, MODE_DEC, 9);
        chk("gap_hold", int'(op), 7);
        step(1'b0, 1'b1, MODE_DEC, 4);
        step(1'b0, 1'b0, MODE_ENC, 0);
        chk("gap_hold2", int'(op), 1);

        // Mid-stream reset discards the in-flight result for operand 2.
        step(1'b0, 1'b1, MODE_ENC, 1);
        step(1'b1, 1'b1, MODE_ENC, 2);
        chk("mid_rst_op", int'(op), 0);
        step(1'b0, 1'b1, MODE_ENC, 3);
        chk("after_mid_rst", int'(op), 6);

        // Package reference function against plain arithmetic.
        for (int i = 0; i < 16; i++) begin
            ref_v = excess3_ref(4'(i), MODE_ENC);
            chk("pkg_enc", int'(ref_v), i + 3);
            ref_v = excess3_ref(4'(i), MODE_DEC);
            chk("pkg_dec", int'(ref_v), ((i < 3) ? 16 : 0) + (i + 13) % 16);
        end

        // Random traffic with occasional resets.
        for (int n = 0; n < 300; n++) begin
            rr  = ($urandom_range(0, 19) == 0);
            riv = ($urandom_range(0, 3) != 0);
            rmd = 1'($urandom_range(0, 1));
            rv  = int'($urandom_range(0, 15));
            step(rr, riv, rmd, rv);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
